// File: rtl/tcp_app_notif_ctrl.sv
// tcp_app_notif_ctrl: control FSM for new-flow notifications.
// Accepts one request, looks up the destination CAM, then either pushes a
// notification flit to NoC0 (hit) or drops it (miss). Only one notification
// is in flight at a time, so the datapath input latches are never overwritten.
module tcp_app_notif_ctrl #(
  parameter int CAM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        app_new_flow_notif_val,
  output logic        app_new_flow_notif_rdy,
  output logic        ctrl_datap_store_inputs,
  output logic        ctrl_datap_read_cam,
  input  logic        datap_ctrl_cam_hit,
  output logic        tcp_rx_notif_if_noc0_val,
  input  logic        noc0_tcp_rx_notif_if_rdy,
  output logic [31:0] notif_sent_cnt,
  output logic [15:0] notif_drop_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_CAM   = 2'd1,
    S_CAM_WAIT = 2'd2,
    S_SEND     = 2'd3
  } state_t;

  // CAM_WAIT lasts CAM_RD_LAT cycles; the counter reaches zero in the last one.
  localparam logic [1:0] LP_WAIT_LOAD = 2'(CAM_RD_LAT - 1);

  state_t      r_state;
  logic [1:0]  r_wait_cnt;
  logic [31:0] r_sent_cnt;
  logic [15:0] r_drop_cnt;
  logic        r_rdy;
  logic        r_rd_cam;
  logic        r_noc_val;
  logic        r_busy;
  logic        w_accept;

  // Drop counter sticks at its maximum rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Registered state flags are forced low while reset is held so that no
  // handshake or datapath strobe is seen during reset.
  assign app_new_flow_notif_rdy   = r_rdy & rst;
  assign ctrl_datap_read_cam      = r_rd_cam & rst;
  assign tcp_rx_notif_if_noc0_val = r_noc_val & rst;
  assign busy                     = r_busy & rst;
  assign w_accept                 = app_new_flow_notif_rdy & app_new_flow_notif_val;
  assign ctrl_datap_store_inputs  = w_accept;
  assign notif_sent_cnt           = r_sent_cnt;
  assign notif_drop_cnt           = r_drop_cnt;

  // Notification FSM with registered per-state output flags and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
      r_rdy      <= 1'b1;
      r_rd_cam   <= 1'b0;
      r_noc_val  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_RD_CAM;
            r_rdy    <= 1'b0;
            r_rd_cam <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_RD_CAM: begin
          r_wait_cnt <= LP_WAIT_LOAD;
          r_rd_cam   <= 1'b0;
          r_state    <= S_CAM_WAIT;
        end
        S_CAM_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            if (datap_ctrl_cam_hit) begin
              r_state   <= S_SEND;
              r_noc_val <= 1'b1;
            end else begin
              r_drop_cnt <= sat_inc16(r_drop_cnt);
              r_state    <= S_IDLE;
              r_rdy      <= 1'b1;
              r_busy     <= 1'b0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        S_SEND: begin
          if (noc0_tcp_rx_notif_if_rdy) begin
            r_sent_cnt <= r_sent_cnt + 32'd1;
            r_noc_val  <= 1'b0;
            r_rdy      <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rdy     <= 1'b1;
          r_rd_cam  <= 1'b0;
          r_noc_val <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_app_notif_ctrl.sv
// Testbench for tcp_app_notif_ctrl: two instances (CAM_RD_LAT 1 and 4) driven
// by directed vectors, checked every cycle against a timeline model plus
// hand-computed literal expectations.
module tb_tcp_app_notif_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn = 2'b00;
  logic [1:0]  val  = 2'b00;
  logic [1:0]  hit  = 2'b00;
  logic [1:0]  nrdy = 2'b11;
  logic        rdy   [2];
  logic        store [2];
  logic        rdc   [2];
  logic        noc   [2];
  logic        bsy   [2];
  logic [31:0] sent0, sent1;
  logic [15:0] drop0, drop1;

  tcp_app_notif_ctrl #(.CAM_RD_LAT(1)) dut0 (
    .clk(clk), .rst(rstn[0]),
    .app_new_flow_notif_val(val[0]), .app_new_flow_notif_rdy(rdy[0]),
    .ctrl_datap_store_inputs(store[0]), .ctrl_datap_read_cam(rdc[0]),
    .datap_ctrl_cam_hit(hit[0]), .tcp_rx_notif_if_noc0_val(noc[0]),
    .noc0_tcp_rx_notif_if_rdy(nrdy[0]), .notif_sent_cnt(sent0),
    .notif_drop_cnt(drop0), .busy(bsy[0])
  );

  tcp_app_notif_ctrl #(.CAM_RD_LAT(4)) dut1 (
    .clk(clk), .rst(rstn[1]),
    .app_new_flow_notif_val(val[1]), .app_new_flow_notif_rdy(rdy[1]),
    .ctrl_datap_store_inputs(store[1]), .ctrl_datap_read_cam(rdc[1]),
    .datap_ctrl_cam_hit(hit[1]), .tcp_rx_notif_if_noc0_val(noc[1]),
    .noc0_tcp_rx_notif_if_rdy(nrdy[1]), .notif_sent_cnt(sent1),
    .notif_drop_cnt(drop1), .busy(bsy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a notification is in flight for a number of cycles measured from
  // acceptance (age 1 = CAM read, age 1+LAT = hit sample), then sends.
  bit          m_in   [2];
  int          m_age  [2];
  bit          m_snd  [2];
  logic [31:0] m_sinc [2];
  logic [31:0] m_dinc [2];
  logic [31:0] b_sent [2] = '{32'd0, 32'd0};
  logic [31:0] b_drop [2] = '{32'd0, 32'd0};
  logic [1:0]  want_hit = 2'b11;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn[i]) begin
        m_in[i]   <= 1'b0;
        m_age[i]  <= 0;
        m_snd[i]  <= 1'b0;
        m_sinc[i] <= 32'd0;
        m_dinc[i] <= 32'd0;
      end else if (!m_in[i]) begin
        if (val[i]) begin
          m_in[i]  <= 1'b1;
          m_age[i] <= 1;
          m_snd[i] <= 1'b0;
        end
      end else if (m_snd[i]) begin
        if (nrdy[i]) begin
          m_sinc[i] <= m_sinc[i] + 32'd1;
          m_in[i]   <= 1'b0;
          m_snd[i]  <= 1'b0;
        end
      end else if (m_age[i] == 1 + lat(i)) begin
        if (hit[i]) m_snd[i] <= 1'b1;
        else begin
          m_dinc[i] <= m_dinc[i] + 32'd1;
          m_in[i]   <= 1'b0;
        end
      end else begin
        m_age[i] <= m_age[i] + 1;
      end
    end
  end

  function automatic bit sample_now(input int i);
    return m_in[i] && !m_snd[i] && (m_age[i] == 1 + lat(i));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    logic [52:0] act, exp;
    logic [31:0] td;
    logic        e_rdy;
    for (int i = 0; i < 2; i++) begin
      e_rdy = rstn[i] && !m_in[i];
      td    = b_drop[i] + m_dinc[i];
      exp = {e_rdy, e_rdy && val[i],
             rstn[i] && m_in[i] && !m_snd[i] && (m_age[i] == 1),
             rstn[i] && m_snd[i], rstn[i] && m_in[i],
             b_sent[i] + m_sinc[i],
             (td > 32'hFFFF) ? 16'hFFFF : td[15:0]};
      act = {rdy[i], store[i], rdc[i], noc[i], bsy[i],
             (i == 0) ? sent0 : sent1, (i == 0) ? drop0 : drop1};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model inst%0d got %h expected %h at %0t", i, act, exp, $time);
      end
    end
  endtask

  // One cycle: inputs applied just after the edge, outputs compared at negedge.
  task automatic cyc(input logic [1:0] v, input logic [1:0] nr, input logic [1:0] rs);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (!rstn[i]) begin
        b_sent[i] = 32'd0;
        b_drop[i] = 32'd0;
      end
    val  = v;
    nrdy = nr;
    rstn = rs;
    for (int i = 0; i < 2; i++)
      hit[i] = sample_now(i) ? want_hit[i] : 1'($urandom);
    @(negedge clk);
    cmp_all();
  endtask

  // One request on instance 0 (CAM_RD_LAT=1, NoC ready): cycles c0..c3.
  task automatic req0(input bit h);
    want_hit[0] = h;
    cyc(2'b01, 2'b11, 2'b11);
    for (int k = 0; k < 3; k++) cyc(2'b00, 2'b11, 2'b11);
  endtask

  initial begin
    // Reset
    cyc(2'b00, 2'b11, 2'b00);
    chk("rst_rdy", 32'(rdy[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_sent", sent0, 32'd0);
    chk("rst_drop", 32'(drop0), 32'd0);
    cyc(2'b00, 2'b11, 2'b00);

    // Single hit: store at c0, read_cam at c1, noc val at c3 only
    want_hit = 2'b11;
    cyc(2'b01, 2'b11, 2'b11);
    chk("hit_store_c0", 32'(store[0]), 32'd1);
    cyc(2'b00, 2'b11, 2'b11);
    chk("hit_rdcam_c1", 32'(rdc[0]), 32'd1);
    cyc(2'b00, 2'b11, 2'b11);
    chk("hit_noc_c2", 32'(noc[0]), 32'd0);
    cyc(2'b00, 2'b11, 2'b11);
    chk("hit_noc_c3", 32'(noc[0]), 32'd1);
    cyc(2'b00, 2'b11, 2'b11);
    chk("hit_noc_c4", 32'(noc[0]), 32'd0);
    chk("hit_sent", sent0, 32'd1);

    // Miss: rdy back two cycles after read_cam, drop counted
    req0(1'b0);
    chk("miss_rdy_c3", 32'(rdy[0]), 32'd1);
    chk("miss_drop", 32'(drop0), 32'd1);
    chk("miss_sent", sent0, 32'd1);

    // NoC backpressure with val held high throughout
    want_hit[0] = 1'b1;
    for (int k = 0; k <= 14; k++) cyc(2'b01, 2'b10, 2'b11);
    chk("bp_noc_held", 32'(noc[0]), 32'd1);
    chk("bp_rdy_low", 32'(rdy[0]), 32'd0);
    chk("bp_store_low", 32'(store[0]), 32'd0);
    cyc(2'b00, 2'b11, 2'b11);
    cyc(2'b00, 2'b11, 2'b11);
    chk("bp_sent", sent0, 32'd2);
    chk("bp_rdy_back", 32'(rdy[0]), 32'd1);

    // Counter wrap and saturation from preloaded values
    force dut0.r_sent_cnt = 32'hFFFF_FFFF;
    force dut0.r_drop_cnt = 16'hFFFE;
    #1;
    release dut0.r_sent_cnt;
    release dut0.r_drop_cnt;
    b_sent[0] = 32'hFFFF_FFFF - m_sinc[0];
    b_drop[0] = 32'h0000_FFFE - m_dinc[0];
    req0(1'b1);
    cyc(2'b00, 2'b11, 2'b11);
    chk("sent_wrap", sent0, 32'd0);
    req0(1'b0);
    chk("drop_ffff_a", 32'(drop0), 32'h0000_FFFF);
    req0(1'b0);
    req0(1'b0);
    chk("drop_sat", 32'(drop0), 32'h0000_FFFF);

    // Reset while in SEND with NoC stalled
    want_hit[0] = 1'b1;
    cyc(2'b01, 2'b10, 2'b11);
    for (int k = 0; k < 3; k++) cyc(2'b00, 2'b10, 2'b11);
    chk("rsend_noc", 32'(noc[0]), 32'd1);
    cyc(2'b00, 2'b10, 2'b10);
    chk("rsend_noc_rst", 32'(noc[0]), 32'd0);
    cyc(2'b00, 2'b10, 2'b11);
    chk("rsend_noc_after", 32'(noc[0]), 32'd0);
    chk("rsend_rdy", 32'(rdy[0]), 32'd1);
    chk("rsend_sent", sent0, 32'd0);
    chk("rsend_drop", 32'(drop0), 32'd0);

    // CAM_RD_LAT=4, continuous requests: one notification every 7 cycles
    want_hit[1] = 1'b1;
    for (int k = 0; k < 28; k++) begin
      cyc(2'b10, 2'b11, 2'b11);
      if (k == 5) chk("l4_rdcam_c5", 32'(rdc[1]), 32'd0);
      if (k == 6) chk("l4_noc_c6", 32'(noc[1]), 32'd1);
      if (k == 7) chk("l4_store_c7", 32'(store[1]), 32'd1);
    end
    cyc(2'b00, 2'b11, 2'b11);
    chk("l4_sent", sent1, 32'd4);
    cyc(2'b00, 2'b11, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
